// File: rtl/switch_input_pkg.sv
// Shared definitions for the switch/button input controller: register map.
package switch_input_pkg;

  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    REG_SWITCH  = 2'd0,
    REG_PENDING = 2'd1,
    REG_MASK    = 2'd2,
    REG_EDGE    = 2'd3
  } reg_addr_e;

endpackage

// File: rtl/switch_input_ctrl_if.sv
// Register bus control signals and interrupt line of the switch input controller.
// The 32-bit tristate data bus stays a plain inout port on the controller.
interface switch_input_ctrl_if;
  logic [1:0] address;
  logic       read;
  logic       write;
  logic       interupt;

  modport master (output address, read, write, input interupt);
  modport slave  (input address, read, write, output interupt);
endinterface

// File: rtl/switch_input_ctrl_debounce.sv
// One-bit input conditioner: 2-flop synchroniser followed by a stable-count debouncer.
module debounce_cell #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic din,
  output logic dout
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  // Synchronise the raw level, then accept it once it has differed for DEBOUNCE_CYCLES cycles.
  // The compare against LAST commits on the cycle the count would reach DEBOUNCE_CYCLES.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      dout  <= 1'b0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
      if (sync2 == dout) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        dout <= sync2;
        cnt  <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/switch_input_ctrl.sv
// Switch/button input controller: debounced inputs, pending/mask/edge registers,
// level interrupt and a 4-register tristate read/write bus.
module switch_input_ctrl
  import switch_input_pkg::*;
#(
  parameter int unsigned SW_WIDTH        = 8,
  parameter int unsigned NUM_BUTTONS     = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  inout  wire  [DATA_W-1:0]      data,
  switch_input_ctrl_if.slave     bus,
  input  logic [SW_WIDTH-1:0]    switches,
  input  logic [NUM_BUTTONS-1:0] buttons
);

  logic [SW_WIDTH-1:0]    sw_deb;
  logic [NUM_BUTTONS-1:0] btn_deb;
  logic [NUM_BUTTONS-1:0] btn_prev;
  logic [NUM_BUTTONS-1:0] pend;
  logic [NUM_BUTTONS-1:0] mask;
  logic [NUM_BUTTONS-1:0] edge_sel;
  logic [NUM_BUTTONS-1:0] evt;
  logic [NUM_BUTTONS-1:0] clr;
  logic                   irq;
  logic                   wr_en;
  reg_addr_e              addr;
  logic [DATA_W-1:0]      rdata;
  logic                   unused_data_hi;

  for (genvar i = 0; i < SW_WIDTH; i++) begin : g_sw
    debounce_cell #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cell (
      .clock (clock),
      .reset (reset),
      .din   (switches[i]),
      .dout  (sw_deb[i])
    );
  end

  for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_btn
    debounce_cell #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cell (
      .clock (clock),
      .reset (reset),
      .din   (buttons[i]),
      .dout  (btn_deb[i])
    );
  end

  assign addr           = reg_addr_e'(bus.address);
  assign unused_data_hi = ^data[DATA_W-1:NUM_BUTTONS];

  // Edge events per button and write-1-clear mask; a read in the same cycle suppresses the write.
  always_comb begin
    wr_en = bus.write & ~bus.read;
    evt   = (edge_sel & btn_prev & ~btn_deb) | (~edge_sel & ~btn_prev & btn_deb);
    clr   = '0;
    if (wr_en && addr == REG_PENDING) begin
      clr = data[NUM_BUTTONS-1:0];
    end
  end

  // Register state; a set event overrides a clear on the same bit.
  always_ff @(posedge clock) begin
    if (reset) begin
      btn_prev <= '0;
      pend     <= '0;
      mask     <= '0;
      edge_sel <= '0;
      irq      <= 1'b0;
    end else begin
      btn_prev <= btn_deb;
      pend     <= (pend & ~clr) | evt;
      irq      <= |(pend & mask);
      if (wr_en && addr == REG_MASK) begin
        mask <= data[NUM_BUTTONS-1:0];
      end
      if (wr_en && addr == REG_EDGE) begin
        edge_sel <= data[NUM_BUTTONS-1:0];
      end
    end
  end

  // Combinational read mux, zero-extended.
  always_comb begin
    rdata = '0;
    unique case (addr)
      REG_SWITCH:  rdata[SW_WIDTH-1:0]    = sw_deb;
      REG_PENDING: rdata[NUM_BUTTONS-1:0] = pend;
      REG_MASK:    rdata[NUM_BUTTONS-1:0] = mask;
      REG_EDGE:    rdata[NUM_BUTTONS-1:0] = edge_sel;
      default:     rdata                  = '0;
    endcase
  end

  assign data         = bus.read ? rdata : 'z;
  assign bus.interupt = irq;

endmodule

// File: doc/switch_input_ctrl.md
SWITCH_INPUT_CTRL -- requirements
Module: switch_input_ctrl

Interface
REQ-001 Parameter SW_WIDTH, default 8, number of switch inputs (legal 1..32).
REQ-002 Parameter NUM_BUTTONS, default 4, number of button inputs (legal 1..16).
REQ-003 Parameter DEBOUNCE_CYCLES, default 16, number of consecutive stable cycles required before a debounced value changes (legal 2..65535).
REQ-004 clock  input  1  single system clock; all state SHALL update on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 data  inout  32  bus data; driven only while read=1, otherwise high-impedance.
REQ-007 address  input  2  register select.
REQ-008 read  input  1  register read strobe.
REQ-009 write  input  1  register write strobe; data sampled on the same edge.
REQ-010 interupt  output  1  level interrupt request.
REQ-011 switches  input  SW_WIDTH  raw asynchronous switch levels.
REQ-012 buttons  input  NUM_BUTTONS  raw asynchronous button levels, 1 = pressed.

Function
REQ-013 Every switch and button bit SHALL pass through a 2-flop synchroniser, then a per-bit debouncer.
REQ-014 Debouncer: per-bit counter; counter clears whenever the synchronised value equals the debounced value; otherwise it increments, and on reaching DEBOUNCE_CYCLES the debounced value takes the synchronised value and the counter clears.
REQ-015 Pin-to-debounced latency SHALL be exactly 2 + DEBOUNCE_CYCLES cycles for a clean step; a glitch shorter than DEBOUNCE_CYCLES cycles SHALL leave the debounced value unchanged.
REQ-016 Address 0 (SWITCH), read-only: debounced switches zero-extended to 32 bits; writes ignored.
REQ-017 Address 1 (PENDING): bits [NUM_BUTTONS-1:0] pending flags; writing 1 to a bit clears it, writing 0 has no effect.
REQ-018 Address 2 (MASK), read/write: bit i = 1 enables button i onto interupt.
REQ-019 Address 3 (EDGE), read/write: bit i = 0 selects press (0->1) events, 1 selects release (1->0) events for button i.
REQ-020 Unused upper bits of all registers SHALL read 0 and ignore writes.
REQ-021 Pending bit i SHALL set on the cycle after debounced button i makes the transition selected by EDGE bit i, irrespective of MASK.
REQ-022 Simultaneous set event and write-1-clear on the same bit: set SHALL win.
REQ-023 interupt SHALL be a registered |(PENDING & MASK), asserting one cycle after the pending/mask change that causes it.
REQ-024 Reads SHALL be combinational from current register state; read and write both high: read data returned, write ignored.
REQ-025 Changing EDGE SHALL NOT by itself create a pending event.

Reset
REQ-026 On reset: PENDING = 0, MASK = 0, EDGE = 0, interupt = 0, all debounce counters = 0, synchroniser flops = 0, debounced values = 0.
REQ-027 Reset asserted mid-debounce SHALL discard the partial count; an input held high through reset SHALL reach debounced 1 exactly 2 + DEBOUNCE_CYCLES cycles after reset deasserts and SHALL then generate a press event.

Structure
REQ-028 Register address constants (SWITCH=0, PENDING=1, MASK=2, EDGE=3) SHALL live in a shared package switch_input_pkg.
REQ-029 A single sub-module debounce_cell (synchroniser + counter + debounced flop, one bit, parameter DEBOUNCE_CYCLES) SHALL be instantiated SW_WIDTH + NUM_BUTTONS times via generate.
REQ-030 Counter width SHALL be $clog2(DEBOUNCE_CYCLES+1).

Verification (bench with DEBOUNCE_CYCLES=4, SW_WIDTH=8, NUM_BUTTONS=4)
REQ-031 switches 0x00->0xA5 step; read address 0 -> 0x00000000 through cycle 5, 0x000000A5 from cycle 6 onward.
REQ-032 button0 high 3 cycles then low -> no debounced change, PENDING stays 0, interupt stays 0.
REQ-033 MASK=0x1, button0 held high 10 cycles -> PENDING=0x1 at cycle 7, interupt=1 at cycle 8; write 0x1 to PENDING -> interupt=0 one cycle later.
REQ-034 MASK=0x0, button2 press -> PENDING=0x4, interupt 0; write MASK=0x4 -> interupt=1 next cycle.
REQ-035 EDGE=0x2, button1 press then release -> PENDING bit1 sets only after release; write-1-clear issued on the set cycle -> bit1 remains 1.
REQ-036 reset asserted at count 3 of a button3 press -> all registers 0; button3 still high -> PENDING=0x8 at cycle 7 after reset release; read=0 -> data high-impedance.
